m68k_bus_ctrl: RTL
==================

Name: m68k_bus_ctrl

Overview:
Sequences every 68000 bus cycle once the address decode has produced its chip-selects. Converts the select class into a DTACK with the correct latency for that class:
- ROM reads go through an SDRAM request/acknowledge handshake.
- Block-RAM regions get a fixed wait count.
- I/O registers get a short wait count.
The block sits between the address decoder, the SDRAM controller's CPU port and the 68000 core.

Parameters:
BRAM_WAIT, 1, extra clk_sys cycles before DTACK for block-RAM selects (0-15)
IO_WAIT, 0, extra clk_sys cycles before DTACK for I/O selects (0-15)
SDR_TIMEOUT, 63, cycles to wait for sdr_ack before forcing completion (1-255)
ROM_AW, 23, word-address width toward SDRAM

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous active-high reset
m68k_as_n  in  1  address strobe
m68k_rw  in  1  1=read, 0=write
m68k_a  in  23  word address m68k_a[23:1]
rom_cs  in  1  ROM region select (already qualified by AS)
bram_cs  in  1  OR of all block-RAM region selects
io_cs  in  1  OR of input/scroll/latch/irq selects
sdr_req  out  1  level request to SDRAM, held until sdr_ack
sdr_addr  out  ROM_AW  latched word address
sdr_ack  in  1  one-cycle acknowledge, data valid same cycle
sdr_data  in  16  SDRAM read data
rom_dout  out  16  latched ROM word for CPU data mux
m68k_dtack_n  out  1  data acknowledge to 68000
unmapped  out  1  one-cycle pulse: cycle with no select
timeout  out  1  one-cycle pulse: SDRAM ack not received in SDR_TIMEOUT
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values: sdr_req=0, sdr_addr=0, rom_dout=16'hFFFF, m68k_dtack_n=1, unmapped=0, timeout=0, busy=0, state=IDLE, wait counter=0.
- States: IDLE, ROM_WAIT, DRAIN, COUNT, ACK.
- A new cycle starts only in IDLE with m68k_as_n=0. Select priority is rom_cs > bram_cs > io_cs.
- IDLE, rom_cs, rw=1:
  - Latch sdr_addr=m68k_a, set sdr_req=1, clear the timeout counter, go to ROM_WAIT.
  - sdr_req is high in cycle 1, where cycle 0 is the cycle in which AS is sampled low.
- IDLE, rom_cs, rw=0: the write is ignored. No SDRAM request is issued. Load counter 0 and go to COUNT, so DTACK comes at cycle 1.
- IDLE, bram_cs: load counter=BRAM_WAIT, go to COUNT.
- IDLE, io_cs: load counter=IO_WAIT, go to COUNT.
- IDLE, no select:
  - unmapped=1 for one cycle and go to ACK, so DTACK comes at cycle 1.
  - rom_dout is unchanged.
- COUNT:
  - If AS is high, go to IDLE (aborted cycle, no DTACK).
  - Else if counter==0, go to ACK.
  - Else decrement the counter.
  - DTACK falls at cycle 1+WAIT.
- ROM_WAIT:
  - On sdr_ack: rom_dout<=sdr_data, sdr_req<=0, go to ACK. DTACK is low in the cycle after the ack.
  - If the counter reaches SDR_TIMEOUT without an ack: timeout pulse, rom_dout<=16'hFFFF, sdr_req<=0, go to ACK.
  - If AS goes high before the ack: go to DRAIN. sdr_req stays asserted because an SDRAM access is never abandoned.
  - Ack and AS-high in the same cycle: treat as ack with AS high. Capture the data, drop sdr_req, go to IDLE, no DTACK.
- DRAIN:
  - Wait for sdr_ack or timeout, then drop sdr_req and go to IDLE. DTACK is never asserted.
  - A new AS while in DRAIN is held off until IDLE.
- ACK:
  - m68k_dtack_n=0 while AS stays low.
  - When AS is sampled high: m68k_dtack_n<=1 and go to IDLE on the same edge.
  - Back-to-back cycles need AS high for at least one sample.
- busy is combinational from the state register.
- Counters are 8-bit and saturate; they never wrap.
- Reset mid-operation: all outputs return to reset values on the next edge, including an outstanding sdr_req. An sdr_ack arriving after reset is ignored.

Test Plan:
- ROM read, a[23:1]=23'h01234, sdr_ack 5 cycles after sdr_req with sdr_data=16'hBEEF -> sdr_addr=23'h01234, rom_dout=16'hBEEF, DTACK low exactly 1 cycle after the ack, released the cycle after AS rises.
- BRAM access with BRAM_WAIT=1, then IO access with IO_WAIT=0 -> DTACK low at cycle 2 and cycle 1 respectively, no sdr_req activity.
- ROM read with sdr_ack never asserted, SDR_TIMEOUT=63 -> timeout pulse at cycle 64, rom_dout=16'hFFFF, DTACK low the next cycle, sdr_req low.
- ROM read, AS released 2 cycles after request, ack 6 cycles later -> DTACK never asserted, sdr_req held until the ack, busy=1 through DRAIN, next AS accepted only after IDLE.
- AS low with no select -> unmapped pulses once, DTACK at cycle 1; ROM write (rw=0) -> DTACK at cycle 1, sdr_req stays 0.
- reset asserted while in ROM_WAIT -> next edge: sdr_req=0, dtack_n=1, busy=0, rom_dout=16'hFFFF; a subsequent stray sdr_ack changes nothing.

Source files
------------

// File: rtl/m68k_bus_ctrl.sv
// rtl/m68k_bus_ctrl.sv - 68000 bus-cycle sequencer: chip-select class to DTACK timing
//
// Purpose:
//   Runs one 68000 bus cycle at a time once the address decoder has produced
//   its selects. ROM reads are forwarded to the SDRAM CPU port as a level
//   request/acknowledge handshake. Block-RAM and I/O selects complete after a
//   fixed number of wait cycles. A strobe with no select is acknowledged
//   immediately and flagged as unmapped.
//
// Ports:
//   clk_sys_i        system clock
//   reset_i          synchronous active-high reset
//   m68k_as_n_i      address strobe (active low)
//   m68k_rw_i        1 = read, 0 = write
//   m68k_a_i         word address A[23:1]
//   rom_cs_i         ROM region select
//   bram_cs_i        OR of all block-RAM region selects
//   io_cs_i          OR of input/scroll/latch/irq selects
//   sdr_req_o        level request to SDRAM, held until sdr_ack_i
//   sdr_addr_o       latched word address toward SDRAM
//   sdr_ack_i        one-cycle acknowledge, data valid in the same cycle
//   sdr_data_i       SDRAM read data
//   rom_dout_o       latched ROM word for the CPU data mux
//   m68k_dtack_n_o   data acknowledge to the 68000 (active low)
//   unmapped_o       one-cycle pulse: strobe with no select
//   timeout_o        one-cycle pulse: SDRAM ack missing after SDR_TIMEOUT cycles
//   busy_o           high whenever the sequencer is not idle

module m68k_bus_ctrl #(
    parameter int BRAM_WAIT   = 1,
    parameter int IO_WAIT     = 0,
    parameter int SDR_TIMEOUT = 63,
    parameter int ROM_AW      = 23
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic              m68k_as_n_i,
    input  logic              m68k_rw_i,
    input  logic [22:0]       m68k_a_i,
    input  logic              rom_cs_i,
    input  logic              bram_cs_i,
    input  logic              io_cs_i,
    output logic              sdr_req_o,
    output logic [ROM_AW-1:0] sdr_addr_o,
    input  logic              sdr_ack_i,
    input  logic [15:0]       sdr_data_i,
    output logic [15:0]       rom_dout_o,
    output logic              m68k_dtack_n_o,
    output logic              unmapped_o,
    output logic              timeout_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_WAIT,
        S_DRAIN,
        S_COUNT,
        S_ACK
    } state_t;

    localparam logic [7:0] BRAM_LD  = 8'(BRAM_WAIT);
    localparam logic [7:0] IO_LD    = 8'(IO_WAIT);
    localparam logic [7:0] TMO_LAST = 8'(SDR_TIMEOUT - 1);

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic                sdr_req_q;
    logic [ROM_AW-1:0]   sdr_addr_q;
    logic [15:0]         rom_dout_q;
    logic                dtack_n_q;
    logic                unmapped_q;
    logic                timeout_q;

    // Saturating increment for the SDRAM wait counter.
    logic [7:0]          cnt_inc_d;
    // The edge on which the counter would reach SDR_TIMEOUT.
    logic                tmo_hit_d;

    assign cnt_inc_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign tmo_hit_d = (cnt_q == TMO_LAST);

    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            sdr_req_q  <= 1'b0;
            sdr_addr_q <= '0;
            rom_dout_q <= 16'hFFFF;
            dtack_n_q  <= 1'b1;
            unmapped_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            unmapped_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!m68k_as_n_i) begin
                        if (rom_cs_i) begin
                            if (m68k_rw_i) begin
                                sdr_addr_q <= ROM_AW'(m68k_a_i);
                                sdr_req_q  <= 1'b1;
                                cnt_q      <= 8'd0;
                                state_q    <= S_ROM_WAIT;
                            end else begin
                                // ROM writes are swallowed and acknowledged at once.
                                cnt_q     <= 8'd0;
                                dtack_n_q <= 1'b0;
                                state_q   <= S_COUNT;
                            end
                        end else if (bram_cs_i) begin
                            // DTACK is driven one edge before the counter empties
                            // so it falls at cycle 1+WAIT; a zero wait asserts now.
                            cnt_q     <= BRAM_LD;
                            dtack_n_q <= (BRAM_LD != 8'd0);
                            state_q   <= S_COUNT;
                        end else if (io_cs_i) begin
                            cnt_q     <= IO_LD;
                            dtack_n_q <= (IO_LD != 8'd0);
                            state_q   <= S_COUNT;
                        end else begin
                            unmapped_q <= 1'b1;
                            dtack_n_q  <= 1'b0;
                            state_q    <= S_ACK;
                        end
                    end
                end

                S_ROM_WAIT: begin
                    if (sdr_ack_i) begin
                        rom_dout_q <= sdr_data_i;
                        sdr_req_q  <= 1'b0;
                        if (m68k_as_n_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            dtack_n_q <= 1'b0;
                            state_q   <= S_ACK;
                        end
                    end else if (tmo_hit_d) begin
                        // DTACK follows one cycle later, from the ACK state.
                        timeout_q  <= 1'b1;
                        rom_dout_q <= 16'hFFFF;
                        sdr_req_q  <= 1'b0;
                        state_q    <= m68k_as_n_i ? S_IDLE : S_ACK;
                    end else begin
                        cnt_q <= cnt_inc_d;
                        // The SDRAM access keeps running after the CPU gives up.
                        if (m68k_as_n_i) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (sdr_ack_i || tmo_hit_d) begin
                        sdr_req_q <= 1'b0;
                        timeout_q <= !sdr_ack_i;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end

                S_COUNT: begin
                    if (m68k_as_n_i) begin
                        dtack_n_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (cnt_q == 8'd0) begin
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            dtack_n_q <= 1'b0;
                        end
                    end
                end

                S_ACK: begin
                    if (m68k_as_n_i) begin
                        dtack_n_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        dtack_n_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sdr_req_o      = sdr_req_q;
    assign sdr_addr_o     = sdr_addr_q;
    assign rom_dout_o     = rom_dout_q;
    assign m68k_dtack_n_o = dtack_n_q;
    assign unmapped_o     = unmapped_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule
